y86_fetch_queue: RTL and testbench
==================================

# y86_fetch_queue

Parametrised instruction prefetch queue for the Y86-64 pipeline's fetch stage. It streams FETCH_BYTES bytes per cycle from instruction memory into a circular byte buffer. It presents the instruction at the queue head as a big-endian 10-byte window, with its PC and decoded length, and flags it valid only when all of its bytes are present. It supports redirects (mispredict, ret, restart) with a full flush, and it tags bytes that came from faulting fetches so the fetch stage can raise ADR status.

## Interface
Parameters:
- FETCH_BYTES, 4: bytes per memory read; 1, 2, 4 or 8.
- DEPTH, 32: buffer size in bytes; power of two, at least 10 + 2*FETCH_BYTES.
- RESET_PC, 64'd0: first fetch address after reset.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high.
- imem_req, output, 1: read request this cycle.
- imem_addr, output, 64: byte address of the request; any alignment.
- imem_rvalid, input, 1: response valid; always exactly one cycle after imem_req.
- imem_rdata, input, 8*FETCH_BYTES: byte at imem_addr in bits [8*FETCH_BYTES-1 -: 8], then ascending addresses.
- imem_err, input, 1: the response faulted; qualified by imem_rvalid.
- out_valid, output, 1: the head instruction is complete.
- out_instr, output, 80: head bytes; byte at out_pc in [79:72], zero-filled beyond the occupied bytes.
- out_pc, output, 64: address of the head byte.
- out_len, output, 4: head instruction length.
- out_adr_err, output, 1: at least one of the head's out_len bytes came from an errored fetch.
- consume, input, 1: pop out_len bytes; honoured only when out_valid=1.
- redirect_valid, input, 1: flush and restart.
- redirect_pc, input, 64: restart address.

## Operation
- State:
  - byte buffer with a per-byte err bit;
  - head pointer, tail pointer and count (0..DEPTH);
  - head_pc, fetch_pc, inflight bit;
  - halt_fetch bit.
- Length decode is combinational on the head byte's icode (bits [7:4]):
  - 0, 1, 9 → 1;
  - 2, 6, A, B → 2;
  - 7, 8 → 9;
  - 3, 4, 5 → 10;
  - any other → 1, and the fetch stage reports INS.
- out_valid = count ≥ out_len AND count > 0 AND NOT redirect_valid.
- out_adr_err is 1 if the head byte's err bit is set, even when count < out_len, so faulting streams never deadlock. In that case out_valid = 1 and out_len = count.
- Request rule: imem_req = NOT redirect_valid AND NOT halt_fetch AND (count + inflight*FETCH_BYTES + FETCH_BYTES ≤ DEPTH). This check is conservative and ignores any same-cycle consume.
- imem_addr = fetch_pc. On a request, fetch_pc advances by FETCH_BYTES (mod 2^64) and inflight is set for the next cycle.
- Response (imem_rvalid and not redirecting):
  - write FETCH_BYTES bytes at the tail, with err = imem_err;
  - tail advances mod DEPTH;
  - if imem_err=1, set halt_fetch.
- Consume:
  - head advances by out_len mod DEPTH;
  - head_pc advances by out_len mod 2^64.
- Same-cycle response and consume: count_next = count + FETCH_BYTES − out_len.
- Redirect has priority over everything:
  - count, head and tail are set to 0;
  - head_pc and fetch_pc are set to redirect_pc;
  - inflight and halt_fetch are cleared;
  - a response arriving in the redirect cycle is discarded;
  - consume is ignored;
  - no request is issued in that cycle.
- Never overflows; underflow is impossible because consume is gated by out_valid.

## Timing
- Reset values:
  - imem_req=0 while reset is asserted; imem_addr=RESET_PC;
  - out_valid=0, out_instr=0, out_pc=RESET_PC, out_len=1, out_adr_err=0;
  - count=0, inflight=0, halt_fetch=0.
- First request goes out in the first cycle after reset deasserts (cycle 0).
- Each response is written at the end of its rvalid cycle.
- With FETCH_BYTES=4, the first 1- or 2-byte instruction is valid in cycle 2. A 10-byte instruction is valid in cycle 4.
- Steady state: one request per cycle, limited only by buffer space.
- Redirect in cycle R: the first request to redirect_pc goes out in R+1 and its data is present in R+3.
- Reset asserted mid-operation clears all state asynchronously. An in-flight response arriving after reset release is discarded because inflight=0.

## Test plan
- Reset release with memory holding nop (10), rrmovq (20 12), irmovq (30 F2 …02) at 0 → cycle 2: out_valid=1, out_pc=0, out_len=1. Consume every cycle → out_pc 0, 1, 3. irmovq appears with out_len=10 and out_instr[79:72]=8'h30.
- consume held low → requests stop once count+4 ≤ 32 is violated. count saturates at 32 and never exceeds it. The head is unchanged.
- Redirect to 56 while a request is in flight → the stale response is discarded. The next out_pc=56 with out_instr[79:72]=8'hA0 (pushq), 3 cycles later.
- imem_err on the fetch covering bytes 8–11 while the head is irmovq at 4 → out_adr_err=1, and imem_req stays 0 until redirect.
- FETCH_BYTES=1, DEPTH=16: a 10-byte instruction is valid 11 cycles after reset. The pointers wrap at 16 with the byte order preserved.
- Reset with a fetch_pc near 2^64−4 set by redirect → fetch_pc wraps to 0, and the bytes are assembled in address order.

Source files
------------

// File: rtl/y86_fetch_queue.sv
// Y86-64 instruction prefetch queue: streams FETCH_BYTES per cycle into a circular byte buffer
// and presents the head instruction as a big-endian 10-byte window with its PC, length and fault flag.
module y86_fetch_queue #(
    parameter int          FETCH_BYTES = 4,
    parameter int          DEPTH       = 32,
    parameter logic [63:0] RESET_PC    = 64'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [63:0]              imem_addr,
    input  logic                     imem_rvalid,
    input  logic [8*FETCH_BYTES-1:0] imem_rdata,
    input  logic                     imem_err,
    output logic                     out_valid,
    output logic [79:0]              out_instr,
    output logic [63:0]              out_pc,
    output logic [3:0]               out_len,
    output logic                     out_adr_err,
    input  logic                     consume,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;

    logic [7:0]       data_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    ptr_t             head_q;
    ptr_t             tail_q;
    logic [CW-1:0]    count_q;
    logic [63:0]      head_pc_q;
    logic [63:0]      fetch_pc_q;
    logic             inflight_q;
    logic             halt_q;

    logic [79:0]      win_dat;
    logic [9:0]       win_err;
    logic [3:0]       dec_len;
    logic [3:0]       lim_len;
    logic             fault;
    logic [CW:0]      need;
    logic             rsp_fire;
    logic             pop;
    logic [CW-1:0]    count_next;

    // Head window: only occupied bytes are shown, the rest read as zero.
    always_comb begin
        win_dat = '0;
        win_err = '0;
        for (int i = 0; i < 10; i++) begin
            if (CW'(i) < count_q) begin
                win_dat[79-8*i -: 8] = data_q[head_q + ptr_t'(i)];
                win_err[i]           = err_q[head_q + ptr_t'(i)];
            end
        end
    end

    always_comb begin
        dec_len = 4'd1;
        case (win_dat[79:76])
            4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
            4'h7, 4'h8:             dec_len = 4'd9;
            4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
            default:                dec_len = 4'd1;
        endcase
    end

    // A faulted byte inside the head window releases whatever is present so the stream cannot stall.
    always_comb begin
        fault = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (4'(i) < dec_len) begin
                fault = fault | win_err[i];
            end
        end
        lim_len = (count_q < CW'(dec_len)) ? count_q[3:0] : dec_len;
    end

    assign out_instr   = win_dat;
    assign out_pc      = head_pc_q;
    assign out_adr_err = fault;
    assign out_len     = fault ? lim_len : dec_len;
    assign out_valid   = !redirect_valid && (count_q != '0) &&
                         (fault || (count_q >= CW'(dec_len)));

    assign need = {1'b0, count_q} + (inflight_q ? (CW+1)'(FETCH_BYTES) : '0) + (CW+1)'(FETCH_BYTES);

    assign imem_req   = !reset && !redirect_valid && !halt_q && (need <= (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign rsp_fire   = imem_rvalid && inflight_q && !redirect_valid;
    assign pop        = consume && out_valid;
    assign count_next = count_q + (rsp_fire ? CW'(FETCH_BYTES) : '0) - (pop ? CW'(out_len) : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            head_pc_q  <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            halt_q     <= 1'b0;
        end else if (redirect_valid) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            head_pc_q  <= redirect_pc;
            fetch_pc_q <= redirect_pc;
            inflight_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc_q <= fetch_pc_q + 64'(FETCH_BYTES);
            end
            if (rsp_fire) begin
                tail_q <= tail_q + ptr_t'(FETCH_BYTES);
                if (imem_err) begin
                    halt_q <= 1'b1;
                end
            end
            if (pop) begin
                head_q    <= head_q + ptr_t'(out_len);
                head_pc_q <= head_pc_q + 64'(out_len);
            end
            count_q <= count_next;
        end
    end

    // Byte storage needs no reset: nothing outside the occupied range is ever observed.
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                data_q[tail_q + ptr_t'(k)] <= imem_rdata[8*(FETCH_BYTES-k)-1 -: 8];
                err_q[tail_q + ptr_t'(k)]  <= imem_err;
            end
        end
    end
endmodule

// File: tb/tb_y86_fetch_queue.sv
// Bench for y86_fetch_queue: a 4-byte/32-entry instance and a 1-byte/16-entry instance,
// each fed by a one-cycle-latency memory model, with a scoreboard of expected head instructions.
module tb_y86_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, consume, redirect_valid, imem_rvalid, imem_err;
    logic [63:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic        imem_req, out_valid, out_adr_err;
    logic [63:0] imem_addr, out_pc;
    logic [79:0] out_instr;
    logic [3:0]  out_len;

    logic        rst1, consume1, redirect1, imem_rvalid1, imem_err1;
    logic [63:0] redirect_pc1;
    logic [7:0]  imem_rdata1;
    logic        imem_req1, out_valid1, out_adr_err1;
    logic [63:0] imem_addr1, out_pc1;
    logic [79:0] out_instr1;
    logic [3:0]  out_len1;

    y86_fetch_queue #(.FETCH_BYTES(4), .DEPTH(32), .RESET_PC(64'd0)) u0 (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_len(out_len),
        .out_adr_err(out_adr_err), .consume(consume), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc));

    y86_fetch_queue #(.FETCH_BYTES(1), .DEPTH(16), .RESET_PC(64'd3)) u1 (
        .clk(clk), .reset(rst1), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_rvalid(imem_rvalid1), .imem_rdata(imem_rdata1), .imem_err(imem_err1),
        .out_valid(out_valid1), .out_instr(out_instr1), .out_pc(out_pc1), .out_len(out_len1),
        .out_adr_err(out_adr_err1), .consume(consume1), .redirect_valid(redirect1),
        .redirect_pc(redirect_pc1));

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  len;
        logic [79:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb1[$];
    logic [7:0]  mem [64];
    logic        err_en;
    logic [63:0] err_addr;
    int          req_cnt;
    int          n_pass, n_chk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        if (a < 64'd64) return mem[a[5:0]];
        return a[7:0] ^ 8'hCC;
    endfunction

    function automatic logic [79:0] win(input logic [63:0] pc);
        logic [79:0] w;
        for (int i = 0; i < 10; i++) w[79-8*i -: 8] = mem_byte(pc + 64'(i));
        return w;
    endfunction

    function automatic logic [3:0] exp_len(input logic [7:0] b);
        case (b[7:4])
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    function automatic exp_t mk(input logic [63:0] pc);
        exp_t e;
        e.pc = pc; e.len = exp_len(mem_byte(pc)); e.instr = win(pc);
        return e;
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h12;
        mem[3] = 8'h30; mem[4] = 8'hF2;
        for (int i = 0; i < 8; i++) mem[5+i] = 8'(i + 1);
        mem[13] = 8'h30; mem[14] = 8'hF3;
        for (int i = 0; i < 8; i++) mem[15+i] = 8'(8'h11 + i);
        mem[23] = 8'h10;
        mem[56] = 8'hA0; mem[57] = 8'h0F;
    endtask

    // Memory model: sample the request at the edge, answer one cycle later.
    logic        s_req, s_req1;
    logic [63:0] s_addr, s_addr1;
    always begin
        @(posedge clk);
        s_req = imem_req; s_addr = imem_addr;
        s_req1 = imem_req1; s_addr1 = imem_addr1;
        #1;
        imem_rvalid = s_req;
        for (int k = 0; k < 4; k++) imem_rdata[31-8*k -: 8] = mem_byte(s_addr + 64'(k));
        imem_err = s_req && err_en && (s_addr == err_addr);
        if (s_req) req_cnt++;
        imem_rvalid1 = s_req1;
        imem_rdata1  = mem_byte(s_addr1);
        imem_err1    = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1; consume = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rst1 = 1'b1; consume1 = 1'b0; redirect1 = 1'b0; redirect_pc1 = '0;
        imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
        imem_rvalid1 = 1'b0; imem_rdata1 = '0; imem_err1 = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({imem_req, out_valid, out_adr_err, out_len} !== {3'b000, 4'd1}) $display("FAIL reset_ctrl: got req/vld/err/len %b want 00000001", {imem_req, out_valid, out_adr_err, out_len});
        else n_pass++;
        n_chk++;
        if (out_instr !== 80'd0 || out_pc !== 64'd0 || imem_addr !== 64'd0) $display("FAIL reset_data: got instr %h pc %h addr %h want zeros", out_instr, out_pc, imem_addr);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) $display("FAIL first_req: got req %b addr %h want 1 0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        exp_t e;
        logic [79:0] m;
        int pops = 0;
        sb.push_back(mk(64'd0)); sb.push_back(mk(64'd1)); sb.push_back(mk(64'd3));
        for (int c = 1; c <= 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (out_valid !== 1'b0) $display("FAIL stream_cycle1: got valid %b want 0", out_valid);
                else n_pass++;
            end
            consume = 1'b0;
            if (out_valid) begin
                e = sb.pop_front();
                if (pops == 0) begin
                    n_chk++;
                    if (c != 2) $display("FAIL first_valid_cycle: got %0d want 2", c);
                    else n_pass++;
                end
                pops++;
                m = {80{1'b1}} << (8 * (10 - int'(e.len)));
                n_chk++;
                if (out_pc !== e.pc || out_len !== e.len || (out_instr & m) !== (e.instr & m))
                    $display("FAIL stream_head: got pc %h len %0d instr %h want pc %h len %0d instr %h", out_pc, out_len, out_instr, e.pc, e.len, e.instr & m);
                else n_pass++;
                consume = 1'b1;
            end
        end
        @(negedge clk);
        consume = 1'b0;
        n_chk++;
        if (sb.size() != 0) begin $display("FAIL stream_timeout: got %0d left want 0", sb.size()); sb.delete(); end
        else n_pass++;
    endtask

    task automatic test_redirect();
        exp_t e;
        redirect_valid = 1'b1; redirect_pc = 64'd56;
        sb.push_back(mk(64'd56));
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL redir_cycle: got valid %b req %b want 0 0", out_valid, imem_req);
        else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd56) $display("FAIL redir_req: got req %b addr %h want 1 38", imem_req, imem_addr);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL stale_discard: got valid %b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_len !== e.len || out_instr[79:64] !== e.instr[79:64])
            $display("FAIL redir_head: got valid %b pc %h len %0d top %h want 1 %h %0d %h", out_valid, out_pc, out_len, out_instr[79:64], e.pc, e.len, e.instr[79:64]);
        else n_pass++;
    endtask

    task automatic test_full();
        redirect_valid = 1'b1; redirect_pc = 64'd0;
        req_cnt = 0;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (24) @(negedge clk);
        n_chk++;
        if (req_cnt != 8 || imem_req !== 1'b0) $display("FAIL full_reqs: got %0d reqs, req %b want 8 0", req_cnt, imem_req);
        else n_pass++;
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== win(64'd0)) $display("FAIL full_head: got valid %b pc %h instr %h want 1 0 %h", out_valid, out_pc, out_instr, win(64'd0));
        else n_pass++;
    endtask

    task automatic test_fault();
        int reqs = 0;
        mem[4] = 8'h30; mem[5] = 8'hF4;
        err_en = 1'b1; err_addr = 64'd8;
        redirect_valid = 1'b1; redirect_pc = 64'd4;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_adr_err !== 1'b1 || out_pc !== 64'd4 || out_len !== 4'd10)
            $display("FAIL fault_head: got valid %b err %b pc %h len %0d want 1 1 4 10", out_valid, out_adr_err, out_pc, out_len);
        else n_pass++;
        repeat (6) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        n_chk++;
        if (reqs != 0) $display("FAIL fault_halt: got %0d reqs want 0", reqs);
        else n_pass++;
        err_en = 1'b0;
        init_mem();
        redirect_valid = 1'b1; redirect_pc = 64'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b1 || out_adr_err !== 1'b0) $display("FAIL fault_resume: got req %b err %b want 1 0", imem_req, out_adr_err);
        else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        bit got = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC));
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_chk++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffffffffffc", imem_addr);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (imem_addr !== 64'd0) $display("FAIL wrap_addr1: got %h want 0", imem_addr);
        else n_pass++;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                e = sb.pop_front();
                n_chk++;
                if (out_pc !== e.pc || out_len !== e.len || out_instr !== e.instr)
                    $display("FAIL wrap_head: got pc %h len %0d instr %h want %h %0d %h", out_pc, out_len, out_instr, e.pc, e.len, e.instr);
                else n_pass++;
                consume = 1'b1;
            end
        end
        if (!got) begin n_chk++; $display("FAIL wrap_timeout: got no valid want valid"); sb.delete(); end
        @(negedge clk);
        consume = 1'b0;
        n_chk++;
        if (out_pc !== 64'd6) $display("FAIL wrap_pc: got %h want 6", out_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        redirect_valid = 1'b1; redirect_pc = 64'd40;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'd0 || out_instr !== 80'd0)
            $display("FAIL midreset_state: got req %b valid %b pc %h instr %h want 0 0 0 0", imem_req, out_valid, out_pc, out_instr);
        else n_pass++;
        #1 reset = 1'b0;
        sb.push_back(mk(64'd0));
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL midreset_stale: got valid %b want 0", out_valid);
        else n_pass++;
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_len !== e.len || out_instr[79:72] !== e.instr[79:72])
            $display("FAIL midreset_head: got valid %b pc %h len %0d byte %h want 1 %h %0d %h", out_valid, out_pc, out_len, out_instr[79:72], e.pc, e.len, e.instr[79:72]);
        else n_pass++;
    endtask

    task automatic test_narrow();
        exp_t e;
        logic [79:0] m;
        int pops = 0;
        @(negedge clk);
        rst1 = 1'b0;
        sb1.push_back(mk(64'd3)); sb1.push_back(mk(64'd13)); sb1.push_back(mk(64'd23));
        for (int c = 1; c <= 80 && sb1.size() > 0; c++) begin
            @(negedge clk);
            if (c == 10) begin
                n_chk++;
                if (out_valid1 !== 1'b0) $display("FAIL narrow_early: got valid %b want 0", out_valid1);
                else n_pass++;
            end
            consume1 = 1'b0;
            if (out_valid1) begin
                e = sb1.pop_front();
                if (pops == 0) begin
                    n_chk++;
                    if (c != 11) $display("FAIL narrow_latency: got cycle %0d want 11", c);
                    else n_pass++;
                end
                pops++;
                m = {80{1'b1}} << (8 * (10 - int'(e.len)));
                n_chk++;
                if (out_pc1 !== e.pc || out_len1 !== e.len || (out_instr1 & m) !== (e.instr & m))
                    $display("FAIL narrow_head: got pc %h len %0d instr %h want %h %0d %h", out_pc1, out_len1, out_instr1, e.pc, e.len, e.instr & m);
                else n_pass++;
                consume1 = 1'b1;
            end
        end
        @(negedge clk);
        consume1 = 1'b0;
        n_chk++;
        if (sb1.size() != 0) begin $display("FAIL narrow_timeout: got %0d left want 0", sb1.size()); sb1.delete(); end
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_chk = 0; req_cnt = 0;
        err_en = 1'b0; err_addr = '0;
        init_mem();
        test_reset();
        test_stream();
        test_redirect();
        test_full();
        test_fault();
        test_wrap();
        test_reset_mid();
        test_narrow();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
